// File: rtl/ft232r_pkg.sv
// Shared definitions for the FT232R bridge: FSM encodings, default
// clock/baud constants and small constant-function helpers.
package ft232r_pkg;

   localparam int unsigned CLK_FREQ_HZ_DEF = 125_000_000;
   localparam int unsigned BAUD_RATE_DEF   = 2_500_000;
   localparam int unsigned BYTE_W          = 8;

   typedef logic [BYTE_W-1:0] byte_t;

   // Command (RX to logic) handshake states
   localparam logic [1:0] C_IDLE = 2'd0;
   localparam logic [1:0] C_REQ  = 2'd1;
   localparam logic [1:0] C_ACK  = 2'd2;

   // Response (logic to TX) handshake states
   localparam logic [1:0] T_IDLE = 2'd0;
   localparam logic [1:0] T_WAIT = 2'd1;
   localparam logic [1:0] T_BUSY = 2'd2;
   localparam logic [1:0] T_ACK  = 2'd3;

   // Clock cycles per UART bit
   function automatic int unsigned baud_div(input int unsigned clk_hz,
                                            input int unsigned baud);
      return clk_hz / baud;
   endfunction

   // Counter width able to hold 0..n-1 (at least one bit)
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hs_sync_fifo.sv
// Single-clock byte FIFO with registered occupancy count. Writes while
// full and reads while empty are ignored; full/empty come from the count.
module hs_sync_fifo
   import ft232r_pkg::*;
#(
   parameter int unsigned P_DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [BYTE_W-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [BYTE_W-1:0]        head_c,
   output logic [$clog2(P_DEPTH):0] count,
   output logic                     full_c,
   output logic                     empty_c
);

   localparam int unsigned AW = $clog2(P_DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [BYTE_W-1:0] mem [P_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              wr_ok;
   logic              rd_ok;

   assign full_c  = (count == CW'(P_DEPTH));
   assign empty_c = (count == '0);
   assign wr_ok   = wr_en && !full_c;
   assign rd_ok   = rd_en && !empty_c;
   assign head_c  = mem[rd_ptr];

   // Storage array, written only when space is available
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rs232_des.sv
// 8N1 UART deserialiser. Samples mid-bit after a synchronised start edge;
// a frame with a valid stop bit produces a one-cycle wr_en with rx_data.
module rs232_des
   import ft232r_pkg::*;
#(
   parameter int unsigned P_CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
   parameter int unsigned P_BAUD_RATE   = BAUD_RATE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic [BYTE_W-1:0] rx_data,
   output logic              wr_en
);

   localparam int unsigned DIV = baud_div(P_CLK_FREQ_HZ, P_BAUD_RATE);
   localparam int unsigned DW  = cnt_width(DIV);

   logic          rx_meta;
   logic          rx_s;
   logic          busy;
   logic [3:0]    bit_cnt;
   logic [DW-1:0] baud_cnt;
   logic [7:0]    shreg;

   // Two-flop synchroniser for the asynchronous serial input
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Start detect, mid-bit sampling, stop-bit validation
   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= 1'b0;
         bit_cnt  <= '0;
         baud_cnt <= '0;
         shreg    <= '0;
         rx_data  <= '0;
         wr_en    <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         if (!busy) begin
            if (!rx_s) begin
               busy     <= 1'b1;
               bit_cnt  <= '0;
               baud_cnt <= DW'(DIV / 2);
            end
         end else if (baud_cnt == DW'(DIV - 1)) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd0) begin
               // Glitch rejection: start bit must still be low mid-bit
               if (rx_s) begin
                  busy <= 1'b0;
               end else begin
                  bit_cnt <= 4'd1;
               end
            end else if (bit_cnt == 4'd9) begin
               busy <= 1'b0;
               if (rx_s) begin
                  wr_en   <= 1'b1;
                  rx_data <= shreg;
               end
            end else begin
               shreg   <= {rx_s, shreg[7:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else begin
            baud_cnt <= baud_cnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/rs232_ser.sv
// 8N1 UART serialiser. A low tx_fifo_empty while idle loads tx_data and
// sends start, 8 data bits LSB first, stop; done pulses once at frame end.
module rs232_ser
   import ft232r_pkg::*;
#(
   parameter int unsigned P_CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
   parameter int unsigned P_BAUD_RATE   = BAUD_RATE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_fifo_empty,
   input  logic [BYTE_W-1:0] tx_data,
   output logic              tx,
   output logic              done
);

   localparam int unsigned DIV = baud_div(P_CLK_FREQ_HZ, P_BAUD_RATE);
   localparam int unsigned DW  = cnt_width(DIV);

   logic          busy;
   logic [8:0]    shreg;
   logic [3:0]    bit_cnt;
   logic [DW-1:0] baud_cnt;

   // Bit timing and shift-out; the stop bit is a 1 shifted in behind the data
   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= 1'b0;
         shreg    <= '1;
         bit_cnt  <= '0;
         baud_cnt <= '0;
         tx       <= 1'b1;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!busy) begin
            if (!tx_fifo_empty) begin
               busy     <= 1'b1;
               shreg    <= {1'b1, tx_data};
               bit_cnt  <= '0;
               baud_cnt <= '0;
               tx       <= 1'b0;
            end
         end else if (baud_cnt == DW'(DIV - 1)) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
               busy <= 1'b0;
               done <= 1'b1;
               tx   <= 1'b1;
            end else begin
               tx      <= shreg[0];
               shreg   <= {1'b1, shreg[8:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else begin
            baud_cnt <= baud_cnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/ft232r_hs_fifo.sv
// FT232R UART bridge with RX FIFO, watermark CTS# flow control and
// 4-phase req/ack handshakes on both logic-side paths.
// Optional macro FT232R_HS_TX_FLOW_EN: transmit waits for rts_n low;
// when undefined rts_n is ignored.
module ft232r_hs_fifo
   import ft232r_pkg::*;
#(
   parameter int unsigned P_CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
   parameter int unsigned P_BAUD_RATE   = BAUD_RATE_DEF,
   parameter int unsigned P_DEPTH       = 16,
   parameter int unsigned P_CTS_HI_WM   = P_DEPTH - 4,
   parameter int unsigned P_CTS_LO_WM   = P_DEPTH / 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     txd,
   output logic                     rxd,
   input  logic                     rts_n,
   output logic                     cts_n,
   input  logic                     rsp_req,
   output logic                     rsp_ack,
   input  logic [BYTE_W-1:0]        rsp_data,
   output logic                     cmd_req,
   input  logic                     cmd_ack,
   output logic [BYTE_W-1:0]        cmd_data,
   output logic [$clog2(P_DEPTH):0] rx_count,
   output logic                     rx_overflow
);

   localparam int unsigned CW = $clog2(P_DEPTH) + 1;

   logic [BYTE_W-1:0] des_data;
   logic              des_wr;
   logic [BYTE_W-1:0] head_c;
   logic              full_c;
   logic              empty_c;
   logic              pop_c;
   logic              tx_done;
   logic              tx_go_c;
   logic              tx_fifo_empty;

   logic [1:0]        c_state;
   logic [1:0]        c_nxt;
   logic              cmd_req_nxt;
   logic [BYTE_W-1:0] cmd_data_nxt;

   logic [1:0]        t_state;
   logic [1:0]        t_nxt;
   logic              rsp_ack_nxt;
   logic [BYTE_W-1:0] tx_byte;
   logic [BYTE_W-1:0] tx_byte_nxt;
   logic              tx_start;
   logic              tx_start_nxt;

`ifdef FT232R_HS_TX_FLOW_EN
   assign tx_go_c = !rts_n;
`else
   logic unused_rts_c;
   assign unused_rts_c = rts_n;
   assign tx_go_c      = 1'b1;
`endif

   assign tx_fifo_empty = !tx_start;

   rs232_des #(
      .P_CLK_FREQ_HZ (P_CLK_FREQ_HZ),
      .P_BAUD_RATE   (P_BAUD_RATE)
   ) u_des (
      .clk     (clk),
      .rst     (rst),
      .rx      (txd),
      .rx_data (des_data),
      .wr_en   (des_wr)
   );

   rs232_ser #(
      .P_CLK_FREQ_HZ (P_CLK_FREQ_HZ),
      .P_BAUD_RATE   (P_BAUD_RATE)
   ) u_ser (
      .clk           (clk),
      .rst           (rst),
      .tx_fifo_empty (tx_fifo_empty),
      .tx_data       (tx_byte),
      .tx            (rxd),
      .done          (tx_done)
   );

   hs_sync_fifo #(
      .P_DEPTH (P_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (des_wr),
      .wr_data (des_data),
      .rd_en   (pop_c),
      .head_c  (head_c),
      .count   (rx_count),
      .full_c  (full_c),
      .empty_c (empty_c)
   );

   // Sticky overflow: a received byte arrived while the registered count was full
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_overflow <= 1'b0;
      end else if (des_wr && full_c) begin
         rx_overflow <= 1'b1;
      end
   end

   // CTS# with hysteresis between the low and high watermarks
   always_ff @(posedge clk) begin
      if (rst) begin
         cts_n <= 1'b0;
      end else if (rx_count >= CW'(P_CTS_HI_WM)) begin
         cts_n <= 1'b1;
      end else if (rx_count <= CW'(P_CTS_LO_WM)) begin
         cts_n <= 1'b0;
      end
   end

   // Command handshake state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         c_state  <= C_IDLE;
         cmd_req  <= 1'b0;
         cmd_data <= '0;
      end else begin
         c_state  <= c_nxt;
         cmd_req  <= cmd_req_nxt;
         cmd_data <= cmd_data_nxt;
      end
   end

   // Command next-state: present FIFO head, pop on ack, wait for ack release
   always_comb begin
      c_nxt        = c_state;
      cmd_req_nxt  = cmd_req;
      cmd_data_nxt = cmd_data;
      pop_c        = 1'b0;
      case (c_state)
         C_IDLE: begin
            if (!empty_c) begin
               cmd_req_nxt  = 1'b1;
               cmd_data_nxt = head_c;
               c_nxt        = C_REQ;
            end
         end
         C_REQ: begin
            if (cmd_ack) begin
               cmd_req_nxt = 1'b0;
               pop_c       = 1'b1;
               c_nxt       = C_ACK;
            end
         end
         C_ACK: begin
            if (!cmd_ack) begin
               c_nxt = C_IDLE;
            end
         end
         default: begin
            c_nxt       = C_IDLE;
            cmd_req_nxt = 1'b0;
         end
      endcase
   end

   // Response handshake state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         t_state  <= T_IDLE;
         rsp_ack  <= 1'b0;
         tx_byte  <= '0;
         tx_start <= 1'b0;
      end else begin
         t_state  <= t_nxt;
         rsp_ack  <= rsp_ack_nxt;
         tx_byte  <= tx_byte_nxt;
         tx_start <= tx_start_nxt;
      end
   end

   // Response next-state: latch byte, wait for RTS#, one-cycle start, ack on done
   always_comb begin
      t_nxt        = t_state;
      rsp_ack_nxt  = rsp_ack;
      tx_byte_nxt  = tx_byte;
      tx_start_nxt = 1'b0;
      case (t_state)
         T_IDLE: begin
            if (rsp_req) begin
               tx_byte_nxt = rsp_data;
               t_nxt       = T_WAIT;
            end
         end
         T_WAIT: begin
            if (tx_go_c) begin
               tx_start_nxt = 1'b1;
               t_nxt        = T_BUSY;
            end
         end
         T_BUSY: begin
            if (tx_done) begin
               rsp_ack_nxt = 1'b1;
               t_nxt       = T_ACK;
            end
         end
         T_ACK: begin
            if (!rsp_req) begin
               rsp_ack_nxt = 1'b0;
               t_nxt       = T_IDLE;
            end
         end
         default: begin
            t_nxt       = T_IDLE;
            rsp_ack_nxt = 1'b0;
         end
      endcase
   end

endmodule
